// File: rtl/lms_spi_sched_if.sv
// Request/response bus between frame requesters and the LMS SPI scheduler.
// The master drives requests; the slave (scheduler) returns grants and readback.
interface lms_spi_sched_if #(
  parameter int unsigned NREQ = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [2*NREQ-1:0]  req_sel;
  logic [16*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    resp_valid;
  logic [7:0]         resp_data;

  modport master (
    output req_valid, req_sel, req_data, req_last,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_sel, req_data, req_last,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/lms_spi_sched.sv
// Round-robin SPI frame scheduler for the shared LMS1/LMS2/DAC bus: grants one
// requester, shifts its 16-bit frame out MSB first and returns the last 8 miso bits.
module lms_spi_sched #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned CLKDIV  = 4,
  parameter int unsigned GAP     = 2,
  parameter int unsigned LOCK_TO = 256
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  lms_spi_sched_if.slave        bus,
  output logic                  busy_o,
  output logic                  sclk_o,
  output logic                  mosi_o,
  input  logic                  miso_i,
  output logic                  sen_lms1_o,
  output logic                  sen_lms2_o,
  output logic                  sen_dac_o
);

  localparam int unsigned IdxW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntMax = (CLKDIV > GAP) ? CLKDIV : GAP;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned ToW    = $clog2(LOCK_TO + 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShiftHi, StShiftLo, StGap} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            lock_q, lock_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [15:0]     tx_q, tx_d;
  logic [1:0]      sel_q, sel_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      resp_data_q, resp_data_d;

  logic            win_found;
  logic [IdxW-1:0] win_idx;
  logic            div_last;
  logic            frame_act;
  int unsigned     cand;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q     <= StIdle;
      ptr_q       <= IdxW'(NREQ - 1);
      lock_q      <= 1'b0;
      to_cnt_q    <= '0;
      cnt_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      sel_q       <= 2'd3;
      rx_q        <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      to_cnt_q    <= to_cnt_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      sel_q       <= sel_d;
      rx_q        <= rx_d;
      resp_data_q <= resp_data_d;
    end
  end

  // ptr_q is both the RR pointer and the owner of the current/locked frame.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = 0;
    if (lock_q) begin
      win_found = bus.req_valid[ptr_q];
    end else begin
      for (int unsigned i = 1; i <= NREQ; i++) begin
        cand = (32'(ptr_q) + i) % NREQ;
        if (!win_found && bus.req_valid[IdxW'(cand)]) begin
          win_found = 1'b1;
          win_idx   = IdxW'(cand);
        end
      end
    end
  end

  assign div_last = (cnt_q == CntW'(CLKDIV - 1));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    to_cnt_d    = to_cnt_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    sel_d       = sel_q;
    rx_d        = rx_q;
    resp_data_d = resp_data_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        bit_d = '0;
        if (win_found) begin
          state_d  = StSetup;
          tx_d     = bus.req_data[16*win_idx +: 16];
          sel_d    = bus.req_sel[2*win_idx +: 2];
          ptr_d    = win_idx;
          lock_d   = ~bus.req_last[win_idx];
          to_cnt_d = '0;
        end else if (lock_q) begin
          if (to_cnt_q == ToW'(LOCK_TO - 1)) begin
            lock_d   = 1'b0;
            to_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end else begin
          to_cnt_d = '0;
        end
      end
      StSetup: begin
        cnt_d = cnt_q + 1'b1;
        if (div_last) begin
          cnt_d   = '0;
          state_d = StShiftHi;
        end
      end
      StShiftHi: begin
        cnt_d = cnt_q + 1'b1;
        if (div_last) begin
          cnt_d   = '0;
          rx_d    = {rx_q[6:0], miso_i};
          tx_d    = {tx_q[14:0], 1'b0};
          state_d = StShiftLo;
        end
      end
      StShiftLo: begin
        cnt_d = cnt_q + 1'b1;
        if (div_last) begin
          cnt_d = '0;
          if (bit_q == 4'd15) begin
            state_d     = StGap;
            resp_data_d = (sel_q == 2'd3) ? 8'h00 : rx_q;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = StShiftHi;
          end
        end
      end
      StGap: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(GAP - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // After 16 shifts tx_q is all zero, so mosi idles low during the CS hold.
  always_comb begin
    frame_act      = (state_q == StSetup) || (state_q == StShiftHi) || (state_q == StShiftLo);
    busy_o         = (state_q != StIdle);
    sclk_o         = (state_q == StShiftHi);
    mosi_o         = frame_act & tx_q[15];
    sen_lms1_o     = ~(frame_act && (sel_q == 2'd0));
    sen_lms2_o     = ~(frame_act && (sel_q == 2'd1));
    sen_dac_o      = ~(frame_act && (sel_q == 2'd2));
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    if (state_q == StIdle && win_found) begin
      bus.req_ready = NREQ'(1) << win_idx;
    end
    if (state_q == StGap && cnt_q == '0) begin
      bus.resp_valid = NREQ'(1) << ptr_q;
    end
    bus.resp_data = resp_data_q;
  end

endmodule
